// File: rtl/proc_pkg.sv
// Shared datapath constants and types for the processor register file.
//   DATA_W     : register width in bits
//   ADDR_W     : register-select width
//   DEPTH      : number of registers (2**ADDR_W)
//   word_t     : one register word
//   reg_addr_t : one register select
package proc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : proc_pkg

// File: rtl/rb_read_port.sv
// One combinational read port of the register file: a DEPTH:1 word mux.
// Ports:
//   regs_i : all register contents, entry i at regs_i[i]
//   addr_i : register select
//   data_o : contents of the selected register, zero-cycle latency
module rb_read_port
  import proc_pkg::*;
(
  input  logic [DEPTH-1:0][DATA_W-1:0] regs_i,
  input  reg_addr_t                    addr_i,
  output word_t                        data_o
);

  // Select the addressed entry; the select covers every entry, so the
  // zero default is only a structural safety value.
  always_comb begin
    data_o = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_i == reg_addr_t'(i)) begin
        data_o = regs_i[i];
      end else begin
        data_o = data_o;
      end
    end
  end

endmodule : rb_read_port

// File: rtl/register_bank.sv
// General-purpose register file: 16 x 32-bit, two combinational read ports
// and one synchronous write port. R0 is ordinary storage.
// Ports:
//   CLK   : clock, writes on rising edge
//   RST_N : asynchronous active-low reset, clears every register at once
//   RA/RB : read-port A/B register select
//   WC    : write register select
//   WPC   : write data
//   W_RB  : write enable, active high
//   PRA/PRB : contents of register RA/RB (no write bypass)
module register_bank
  import proc_pkg::*;
(
  input  logic      CLK,
  input  logic      RST_N,
  input  reg_addr_t RA,
  input  reg_addr_t RB,
  input  reg_addr_t WC,
  input  word_t     WPC,
  input  logic      W_RB,
  output word_t     PRA,
  output word_t     PRB
);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0]             wr_sel_d;

  // Per-entry write-enable decode.
  always_comb begin
    wr_sel_d = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (W_RB && (WC == reg_addr_t'(i))) begin
        wr_sel_d[i] = 1'b1;
      end else begin
        wr_sel_d[i] = 1'b0;
      end
    end
  end

  // Storage: async clear, otherwise write the selected entry on the edge.
  // A write coinciding with an asserted reset is lost because reset wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel_d[i]) begin
          regs_q[i] <= WPC;
        end
      end
    end
  end

  rb_read_port u_port_a (
    .regs_i (regs_q),
    .addr_i (RA),
    .data_o (PRA)
  );

  rb_read_port u_port_b (
    .regs_i (regs_q),
    .addr_i (RB),
    .data_o (PRB)
  );

endmodule : register_bank

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: a table of write/read vectors
// plus hand-written sequences for reset, no-bypass and random fills.
module tb_register_bank;
  import proc_pkg::*;

  logic      CLK;
  logic      RST_N;
  reg_addr_t RA, RB, WC;
  word_t     WPC;
  logic      W_RB;
  word_t     PRA, PRB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    word_t ea;
    word_t eb;
  } exp_t;

  typedef struct {
    logic      we;
    reg_addr_t wc;
    word_t     wpc;
    reg_addr_t ra;
    reg_addr_t rb;
    word_t     ea;
    word_t     eb;
  } vec_t;

  exp_t  sb_q[$];
  vec_t  tbl[6];
  word_t mdl[DEPTH];

  register_bank dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .RA    (RA),
    .RB    (RB),
    .WC    (WC),
    .WPC   (WPC),
    .W_RB  (W_RB),
    .PRA   (PRA),
    .PRB   (PRB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Drive read addresses, push the expectation, then pop and compare.
  task automatic check_rd(input string nm, input reg_addr_t ra, input reg_addr_t rb,
                          input word_t ea, input word_t eb);
    exp_t e;
    RA = ra;
    RB = rb;
    sb_q.push_back('{ea: ea, eb: eb});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (PRA !== e.ea) begin
      errors++;
      $display("FAIL %s PRA(RA=%0d) got %h want %h", nm, ra, PRA, e.ea);
    end
    checks++;
    if (PRB !== e.eb) begin
      errors++;
      $display("FAIL %s PRB(RB=%0d) got %h want %h", nm, rb, PRB, e.eb);
    end
  endtask

  // One clock edge with the given write-port values; model follows if enabled.
  task automatic drive_edge(input logic we, input reg_addr_t wc, input word_t d);
    @(negedge CLK);
    W_RB = we;
    WC   = wc;
    WPC  = d;
    @(posedge CLK);
    if (we && RST_N) mdl[wc] = d;
    #1;
    W_RB = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0000_0000;
  endtask

  initial begin
    RST_N = 1'b0;
    RA = 4'd3; RB = 4'd9; WC = 4'd0; WPC = 32'h0000_0000; W_RB = 1'b0;
    clear_model();

    // Reset with no clock edge yet, then hold reset across an enabled write.
    #1;
    check_rd("reset_noclk", 4'd3, 4'd9, 32'h0000_0000, 32'h0000_0000);
    W_RB = 1'b1; WC = 4'd3; WPC = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    check_rd("reset_blocks_write", 4'd3, 4'd3, 32'h0000_0000, 32'h0000_0000);
    @(negedge CLK);
    W_RB = 1'b0;
    RST_N = 1'b1;

    // Table: each row is one edge (write or idle) followed by a read check.
    tbl[0] = '{1'b1, 4'd0,  32'hDEAD_BEEF, 4'd0,  4'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 4'd5,  32'h1234_5678, 4'd5,  4'd0,  32'h1234_5678, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 4'd5,  32'h0000_0000, 4'd5,  4'd5,  32'h1234_5678, 32'h1234_5678};
    tbl[3] = '{1'b0, 4'd0,  32'hFFFF_FFFF, 4'd0,  4'd5,  32'hDEAD_BEEF, 32'h1234_5678};
    tbl[4] = '{1'b1, 4'd15, 32'h8000_0001, 4'd15, 4'd0,  32'h8000_0001, 32'hDEAD_BEEF};
    tbl[5] = '{1'b1, 4'd0,  32'h0000_0000, 4'd0,  4'd15, 32'h0000_0000, 32'h8000_0001};
    for (int k = 0; k < 6; k++) begin
      drive_edge(tbl[k].we, tbl[k].wc, tbl[k].wpc);
      @(negedge CLK);
      check_rd($sformatf("table_%0d", k), tbl[k].ra, tbl[k].rb, tbl[k].ea, tbl[k].eb);
    end
    // Extra idle edges with enable low on R5.
    for (int k = 0; k < 3; k++) drive_edge(1'b0, 4'd5, 32'h0000_0000);
    @(negedge CLK);
    check_rd("we_low_hold", 4'd5, 4'd5, 32'h1234_5678, 32'h1234_5678);

    // Random fill and adjacent-pair reads, five rounds.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < DEPTH; i++) drive_edge(1'b1, reg_addr_t'(i), word_t'($urandom));
      for (int i = 0; i < DEPTH - 1; i++) begin
        @(negedge CLK);
        check_rd($sformatf("fill_r%0d_%0d", r, i), reg_addr_t'(i), reg_addr_t'(i + 1),
                 mdl[i], mdl[i + 1]);
      end
    end

    // No bypass: old value before the edge, new value after it.
    drive_edge(1'b1, 4'd7, 32'h0000_000A);
    @(negedge CLK);
    W_RB = 1'b1; WC = 4'd7; WPC = 32'h0000_000B;
    check_rd("nobypass_before", 4'd7, 4'd7, 32'h0000_000A, 32'h0000_000A);
    @(posedge CLK);
    #1;
    W_RB = 1'b0;
    check_rd("nobypass_after", 4'd7, 4'd7, 32'h0000_000B, 32'h0000_000B);

    // Mid-run reset pulse between edges clears everything at once.
    drive_edge(1'b1, 4'd3, 32'hCAFE_F00D);
    @(negedge CLK);
    check_rd("preload_r3", 4'd3, 4'd7, 32'hCAFE_F00D, 32'h0000_000B);
    #1;
    RST_N = 1'b0;
    check_rd("midreset_drop", 4'd3, 4'd7, 32'h0000_0000, 32'h0000_0000);
    #1;
    RST_N = 1'b1;
    clear_model();
    check_rd("midreset_released", 4'd3, 4'd0, 32'h0000_0000, 32'h0000_0000);
    drive_edge(1'b1, 4'd3, 32'h1111_2222);
    @(negedge CLK);
    check_rd("post_reset_write", 4'd3, 4'd7, 32'h1111_2222, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_register_bank
